// File: rtl/layer2_result_writer_pkg.sv
// Shared layer-2 definitions: writer state encoding, datapath defaults and the
// per-filter output-plane base address (also used by the layer-3 readers).
package layer2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RES,
    ST_WRITE,
    ST_REQ,
    ST_DONE
  } l2w_state_e;

  localparam int unsigned L2_DATA_WIDTH = 16;
  localparam int unsigned L2_OUT_DIM    = 10;
  localparam int unsigned L2_NUM_FIL    = 4;

  // Output memory is filter-major: each filter owns one dim x dim plane.
  function automatic int unsigned fil_base(input int unsigned f, input int unsigned dim);
    return f * dim * dim;
  endfunction

endpackage

// File: rtl/layer2_result_writer_if.sv
// Layer-2 write-back bus: result capture from the filters, loader handshake
// and the output-memory write port. master = writer, slave = environment.
interface layer2_result_writer_if
  import layer2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
  parameter int unsigned NUM_FIL    = L2_NUM_FIL,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                          start;
  logic                          ldDone;
  logic                          resValid;
  logic [NUM_FIL*DATA_WIDTH-1:0] resData;
  logic                          wrEn;
  logic [ADDR_WIDTH-1:0]         wrAddr;
  logic [DATA_WIDTH-1:0]         wrData;
  logic                          ldBuf;
  logic                          done;
  logic                          overrun;

  modport master (
    input  start, ldDone, resValid, resData,
    output wrEn, wrAddr, wrData, ldBuf, done, overrun
  );

  modport slave (
    output start, ldDone, resValid, resData,
    input  wrEn, wrAddr, wrData, ldBuf, done, overrun
  );
endinterface

// File: rtl/layer2_result_writer_pos_counter.sv
// Row-major window position counter (row/col with wrap); shared with the
// layer-2 loader so both sides walk positions identically.
module layer2_pos_counter #(
  parameter int unsigned DIM = 10,
  localparam int unsigned CW = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  localparam logic [CW-1:0] MAX = CW'(DIM - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);
endmodule

// File: rtl/layer2_result_writer.sv
// Layer-2 result writer: captures NUM_FIL filter results per window and writes
// them filter-major to output memory. Optional ReLU at write-back: L2W_RELU_EN.
module layer2_result_writer
  import layer2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
  parameter int unsigned OUT_DIM    = L2_OUT_DIM,
  parameter int unsigned NUM_FIL    = L2_NUM_FIL,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  layer2_result_writer_if.master bus
);
  localparam int unsigned CW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned FW = (NUM_FIL > 1) ? $clog2(NUM_FIL) : 1;

  l2w_state_e                         state;
  logic [NUM_FIL-1:0][DATA_WIDTH-1:0] hold;
  logic [FW-1:0]                      fil_cnt;
  logic                               overrun_q;
  logic [CW-1:0]                      b_row, b_col;
  logic                               pos_last;
  logic                               fil_last;
  logic                               rearm;
  logic [DATA_WIDTH-1:0]              res_word;
  logic [ADDR_WIDTH-1:0]              addr_calc;

  assign rearm    = (state == ST_DONE) && bus.start;
  assign fil_last = (fil_cnt == FW'(NUM_FIL - 1));

  layer2_pos_counter #(.DIM(OUT_DIM)) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (rearm),
    .adv  (state == ST_REQ),
    .row  (b_row),
    .col  (b_col),
    .last (pos_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      hold      <= '0;
      fil_cnt   <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.resValid) overrun_q <= 1'b1;
          if (bus.start)    state     <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (bus.resValid) begin
            if (bus.ldDone) begin
              hold    <= bus.resData;
              fil_cnt <= '0;
              state   <= ST_WRITE;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (bus.resValid) overrun_q <= 1'b1;
          fil_cnt <= fil_cnt + 1'b1;
          if (fil_last) state <= pos_last ? ST_DONE : ST_REQ;
        end
        ST_REQ: begin
          if (bus.resValid) overrun_q <= 1'b1;
          state <= ST_WAIT_RES;
        end
        ST_DONE: begin
          // Re-arm wins over a coincident stray resValid: the new frame starts clean.
          if (bus.start) begin
            overrun_q <= 1'b0;
            state     <= ST_WAIT_RES;
          end else if (bus.resValid) begin
            overrun_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef L2W_RELU_EN
  assign res_word = hold[fil_cnt][DATA_WIDTH-1] ? '0 : hold[fil_cnt];
`else
  assign res_word = hold[fil_cnt];
`endif

  assign addr_calc = ADDR_WIDTH'(fil_base(32'(fil_cnt), OUT_DIM))
                   + ADDR_WIDTH'(b_row) * ADDR_WIDTH'(OUT_DIM)
                   + ADDR_WIDTH'(b_col);

  assign bus.wrEn    = (state == ST_WRITE);
  assign bus.wrAddr  = bus.wrEn ? addr_calc : '0;
  assign bus.wrData  = bus.wrEn ? res_word : '0;
  assign bus.ldBuf   = (state == ST_REQ);
  assign bus.done    = (state == ST_DONE);
  assign bus.overrun = overrun_q;
endmodule

// File: doc/layer2_result_writer.md
Name: layer2_result_writer

Overview:
Write-back end of the layer-2 convolution datapath. It captures the four per-filter results produced for each window position and writes them into output memory, one word per cycle, in filter-major, row-major order. It then pulses ldBuf so the layer-2 loader fetches the next 4x4 window. It walks all OUT_DIM x OUT_DIM window positions, then raises done.

Parameters:
DATA_WIDTH, 16, width of one filter result and of an output memory word
OUT_DIM, 10, output feature-map side (positions per row/column)
NUM_FIL, 4, filters per window (results per resValid)
ADDR_WIDTH, 32, output memory address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  level; leaves IDLE, or re-arms from DONE
ldDone  in  1  loader has a window in the buffer (level)
resValid  in  1  one-cycle pulse: resData valid for current position
resData  in  NUM_FIL*DATA_WIDTH  filter f result at bits [f*DATA_WIDTH +: DATA_WIDTH], signed
wrEn  out  1  output memory write strobe
wrAddr  out  ADDR_WIDTH  output memory word address
wrData  out  DATA_WIDTH  output memory write data
ldBuf  out  1  one-cycle pulse: request next window
done  out  1  all positions written (level)
overrun  out  1  sticky error: resValid arrived while not accepting

Behaviour:
- Reset (rst=0, async) sets the following: state IDLE; counters b_row, b_col and fil_cnt to 0; result holding register to 0; overrun to 0; all outputs 0.
- States are IDLE, WAIT_RES, WRITE, REQ, DONE.
- IDLE: start=1 -> WAIT_RES.
- WAIT_RES: when resValid=1 and ldDone=1, the next cycle latches resData into the holding register, sets fil_cnt=0 and moves to WRITE. resValid with ldDone=0 is ignored and sets overrun.
- WRITE: one write per cycle, NUM_FIL cycles total.
  - wrEn=1, wrData = holding slice fil_cnt.
  - wrAddr = fil_cnt*OUT_DIM*OUT_DIM + b_row*OUT_DIM + b_col, zero-extended to ADDR_WIDTH.
  - fil_cnt increments each cycle.
  - After the fil_cnt=NUM_FIL-1 write: if b_row=OUT_DIM-1 and b_col=OUT_DIM-1 -> DONE, else -> REQ.
- REQ: ldBuf=1 for exactly one cycle.
  - b_col advances and wraps OUT_DIM-1 -> 0.
  - b_row increments on b_col wrap.
  - Next state is WAIT_RES.
- DONE: done=1 held. start=1 clears the counters and overrun, then -> WAIT_RES (new frame). No ldBuf is issued in DONE.
- Latency: resValid (cycle N) -> first wrEn at N+1, last at N+NUM_FIL, ldBuf at N+NUM_FIL+1.
- A resValid pulse in WRITE, REQ, IDLE or DONE is dropped and sets overrun (sticky until reset or re-arm).
- Outputs are combinational from state and registers. wrAddr and wrData are 0 when wrEn=0.
- Address arithmetic is unsigned. Intermediate products are at least ADDR_WIDTH bits wide, so there is no truncation for the defaults (max address 399).
- Reset asserted mid-WRITE aborts immediately. Partial writes are not retried.

Optional Feature:
- Macro L2W_RELU_EN.
- Defined: wrData = 0 for any negative result (MSB=1), otherwise the value unchanged (ReLU applied at write-back).
- Undefined: wrData is the raw signed result.
- Timing and addresses are identical in both builds.

Decomposition:
- Shared package layer2_pkg holds:
  - state encoding constants (IDLE..DONE);
  - OUT_DIM, NUM_FIL and DATA_WIDTH defaults;
  - the address-base function f*OUT_DIM*OUT_DIM, also used by layer-3 readers.
- One sub-module, layer2_pos_counter: b_row/b_col with wrap, an advance input and a last flag. It is reusable by the loader side.

Test Plan:
1. Reset, start=1, ldDone=1, one resValid with resData={16'h0004,16'h0003,16'h0002,16'h0001} -> writes (addr,data) (0,1),(100,2),(200,3),(300,4) on 4 consecutive cycles, then one ldBuf pulse, back in WAIT_RES.
2. Full frame: 100 resValid pulses, each issued 2 cycles after ldBuf -> exactly 400 writes; position (9,9) filter 3 lands at addr 399; 99 ldBuf pulses; done=1; no ldBuf after the last write.
3. resValid during WRITE -> ignored, overrun=1 and stays 1, write sequence unaffected; start in DONE clears it.
4. rst=0 on the 2nd WRITE cycle -> wrEn, ldBuf, done and overrun all 0 immediately; after release, IDLE; start resumes at addr 0.
5. L2W_RELU_EN defined, resData slice 0 = 16'hFFF0 and slice 1 = 16'h0007 -> wrData 0 then 7. Undefined build -> 16'hFFF0 then 7.
6. resValid while ldDone=0 in WAIT_RES -> no write, overrun=1, state stays WAIT_RES.
